// File: rtl/cpu_trace_buffer_pkg.sv
// Shared types for the CPU trace buffer: FSM state encoding,
// data word width and the stored {PC, Inst, R} entry record.
package cpu_trace_buffer_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] inst;
        logic [WORD_W-1:0] r;
    } entry_t;

endpackage

// File: rtl/cpu_trace_buffer_trace_ram.sv
// Trace storage: DEPTH x 96-bit, one synchronous write port and
// one asynchronous read port.
// Ports: Clk, i_we/i_waddr/i_wdata (write), i_raddr/o_rdata (read).
module trace_ram
    import cpu_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  entry_t        i_wdata,
    input  logic [AW-1:0] i_raddr,
    output entry_t        o_rdata
);

    entry_t r_mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular capture buffer for the CPU retired-instruction stream.
// Ports: Clk/Rst_n; PC/Inst/R sample inputs; Arm, Trig_En, Trig_PC
// trigger control; Rd_Valid/Rd_Ready/Rd_* show-ahead readout;
// Count, Overflow, State status.
module cpu_trace_buffer
    import cpu_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int POST  = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [WORD_W-1:0] PC,
    input  logic [WORD_W-1:0] Inst,
    input  logic [WORD_W-1:0] R,
    input  logic              Arm,
    input  logic              Trig_En,
    input  logic [WORD_W-1:0] Trig_PC,
    output logic              Rd_Valid,
    input  logic              Rd_Ready,
    output logic [WORD_W-1:0] Rd_PC,
    output logic [WORD_W-1:0] Rd_Inst,
    output logic [WORD_W-1:0] Rd_R,
    output logic [CW-1:0]     Count,
    output logic              Overflow,
    output logic [1:0]        State
);

    localparam logic [CW-1:0] L_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] L_POST = CW'(POST);
    localparam logic [CW-1:0] L_ONE  = CW'(1);

    state_e        r_state, w_state_nxt;
    logic [AW-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [AW-1:0] r_rd_ptr, w_rd_ptr_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic [CW-1:0] r_post, w_post_nxt;
    logic          r_ovf, w_ovf_nxt;

    logic          w_we;
    logic [AW-1:0] w_waddr;
    entry_t        w_wdata;
    entry_t        w_rdata;
    logic          w_full;
    logic          w_hit;
    logic          w_rd_valid;

    assign w_wdata    = '{pc: PC, inst: Inst, r: R};
    assign w_full     = (r_count == L_FULL);
    assign w_hit      = Trig_En && (PC == Trig_PC);
    assign w_rd_valid = (r_state == ST_DONE) && (r_count != '0);

    trace_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .Clk     (Clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_post   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_post   <= w_post_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        w_post_nxt   = r_post;
        w_ovf_nxt    = r_ovf;
        w_we         = 1'b0;
        w_waddr      = r_wr_ptr;

        unique case (r_state)
            ST_IDLE: begin
                if (Arm) begin
                    w_state_nxt  = ST_ARMED;
                    w_wr_ptr_nxt = '0;
                    w_rd_ptr_nxt = '0;
                    w_count_nxt  = '0;
                    w_post_nxt   = '0;
                    w_ovf_nxt    = 1'b0;
                end
            end

            ST_ARMED, ST_POST: begin
                w_we = 1'b1;
                if (Arm) begin
                    // Restart: this cycle's sample becomes entry 0.
                    w_waddr      = '0;
                    w_state_nxt  = ST_ARMED;
                    w_wr_ptr_nxt = AW'(1);
                    w_rd_ptr_nxt = '0;
                    w_count_nxt  = L_ONE;
                    w_post_nxt   = '0;
                    w_ovf_nxt    = 1'b0;
                end else begin
                    w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                    // Full: oldest entry is overwritten, so the
                    // read pointer follows the write pointer.
                    if (w_full) begin
                        w_rd_ptr_nxt = r_rd_ptr + 1'b1;
                        w_ovf_nxt    = 1'b1;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end

                    if (r_state == ST_ARMED) begin
                        if (w_hit) begin
                            if (POST == 0) begin
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_state_nxt = ST_POST;
                                w_post_nxt  = L_POST;
                            end
                        end
                    end else begin
                        w_post_nxt = r_post - 1'b1;
                        if (r_post == L_ONE) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                if (r_count == '0) begin
                    w_state_nxt = ST_IDLE;
                end else if (Rd_Ready) begin
                    w_rd_ptr_nxt = r_rd_ptr + 1'b1;
                    w_count_nxt  = r_count - 1'b1;
                    if (r_count == L_ONE) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign Rd_Valid = w_rd_valid;
    assign Rd_PC    = w_rd_valid ? w_rdata.pc   : '0;
    assign Rd_Inst  = w_rd_valid ? w_rdata.inst : '0;
    assign Rd_R     = w_rd_valid ? w_rdata.r    : '0;
    assign Count    = r_count;
    assign Overflow = r_ovf;
    assign State    = r_state;

endmodule
